// File: rtl/if_prefetch_pkg.sv
// Shared constants and types for the instruction prefetch stage.
// Also holds the decode helper that classifies a memory response.
package if_prefetch_pkg;

  localparam int          IF_XLEN     = 32;
  localparam logic [31:0] IF_RESET_PC = 32'h8000_0000;
  localparam int          IF_DEPTH    = 4;
  localparam logic        JUMP_ENABLE = 1'b1;
  localparam logic        RST_ENABLE  = 1'b0;

  typedef enum logic [1:0] {
    RESP_NONE,
    RESP_PUSH,
    RESP_DROP
  } resp_action_t;

  // A response is kept only when no redirect has orphaned it.
  function automatic resp_action_t classify_resp(input logic rvalid, input logic drop_zero);
    if (!rvalid)        return RESP_NONE;
    else if (drop_zero) return RESP_PUSH;
    else                return RESP_DROP;
  endfunction

endpackage

// File: rtl/if_fifo.sv
// Synchronous prefetch FIFO with flush, occupancy count and same-cycle push/pop.
// Head data reads as zero while empty so downstream never sees stale entries.
module if_fifo
  import if_prefetch_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             head_valid,
  output logic [WIDTH-1:0] head_data,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (rst_n == RST_ENABLE) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // NOTE: storage has no reset; validity comes from count, which keeps this a plain RAM.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= push_data;
  end

  assign head_valid = (count != '0);
  assign head_data  = head_valid ? mem[rd_ptr] : '0;

  always @(posedge clk) begin
    if (rst_n != RST_ENABLE && !flush) begin
      assert (!(push && !pop && count == CNT_W'(DEPTH)));
    end
  end

endmodule

// File: rtl/if_prefetch.sv
// Instruction fetch stage: issues word fetches over req/gnt/rvalid, buffers
// (pc, inst) pairs for decode and discards responses orphaned by a jump.
module if_prefetch
  import if_prefetch_pkg::*;
#(
  parameter int             XLEN     = IF_XLEN,
  parameter logic [XLEN-1:0] RESET_PC = IF_RESET_PC,
  parameter int             DEPTH    = IF_DEPTH,
  parameter int             CNT_W    = $clog2(DEPTH) + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            jump_flag_i,
  input  logic [XLEN-1:0] jump_addr_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_gnt_i,
  input  logic            imem_rvalid_i,
  input  logic [XLEN-1:0] imem_rdata_i,
  output logic            inst_valid_o,
  output logic [XLEN-1:0] inst_o,
  output logic [XLEN-1:0] inst_pc_o,
  input  logic            inst_ready_i,
  output logic            hold_flag_o
);

  logic            jump;
  logic            grant;
  logic            push;
  logic            pop;
  logic [XLEN-1:0] jump_target;
  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] resp_pc;
  logic [CNT_W-1:0] outstanding;
  logic [CNT_W-1:0] outstanding_next;
  logic [CNT_W-1:0] drop_cnt;
  logic [CNT_W-1:0] drop_next;
  logic [CNT_W-1:0] fifo_count;
  logic [CNT_W:0]   committed;
  resp_action_t     resp_act;

  assign jump        = (jump_flag_i == JUMP_ENABLE);
  assign jump_target = jump_addr_i & ~XLEN'(3);

  // Every issued request owns a FIFO slot until it is consumed, so the FIFO cannot overflow.
  assign committed   = {1'b0, outstanding} + {1'b0, fifo_count};
  assign imem_req_o  = rst_n && !jump && (committed < (CNT_W+1)'(DEPTH));
  assign imem_addr_o = fetch_pc;
  assign grant       = imem_req_o && imem_gnt_i;

  assign resp_act = classify_resp(imem_rvalid_i, drop_cnt == '0);
  assign push     = (resp_act == RESP_PUSH) && !jump;
  assign pop      = inst_valid_o && inst_ready_i && !jump;

  assign outstanding_next = outstanding + CNT_W'(grant) - CNT_W'(imem_rvalid_i);

  // A jump orphans everything still in flight after this cycle's response.
  always_comb begin
    drop_next = drop_cnt;
    if (jump)                         drop_next = outstanding_next;
    else if (resp_act == RESP_DROP)   drop_next = drop_cnt - CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (rst_n == RST_ENABLE) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      outstanding <= outstanding_next;
      drop_cnt    <= drop_next;
      if (jump) begin
        fetch_pc <= jump_target;
        resp_pc  <= jump_target;
      end else begin
        if (grant) fetch_pc <= fetch_pc + XLEN'(4);
        if (push)  resp_pc  <= resp_pc + XLEN'(4);
      end
    end
  end

  if_fifo #(
    .WIDTH (2*XLEN),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (jump),
    .push       (push),
    .push_data  ({resp_pc, imem_rdata_i}),
    .pop        (pop),
    .head_valid (inst_valid_o),
    .head_data  ({inst_pc_o, inst_o}),
    .count      (fifo_count)
  );

  assign hold_flag_o = (fifo_count == '0);

  always @(posedge clk) begin
    if (rst_n != RST_ENABLE) begin
      assert (outstanding <= CNT_W'(DEPTH));
      assert (drop_cnt <= outstanding);
    end
  end

endmodule

// File: tb/tb_if_prefetch.sv
// Self-checking bench for if_prefetch: directed scenarios plus random traffic,
// compared each cycle against an epoch-tagged transaction model of fetch.
module tb_if_prefetch;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        jump_flag;
  logic [31:0] jump_addr;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;
  logic        hold_flag;

  if_prefetch dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .jump_flag_i   (jump_flag),
    .jump_addr_i   (jump_addr),
    .imem_req_o    (imem_req),
    .imem_addr_o   (imem_addr),
    .imem_gnt_i    (imem_gnt),
    .imem_rvalid_i (imem_rvalid),
    .imem_rdata_i  (imem_rdata),
    .inst_valid_o  (inst_valid),
    .inst_o        (inst),
    .inst_pc_o     (inst_pc),
    .inst_ready_i  (inst_ready),
    .hold_flag_o   (hold_flag)
  );

  always #5 clk = ~clk;

  // Model: a request belongs to the program stream (epoch) current at grant time.
  typedef struct {
    logic [31:0] addr;
    int          epoch;
    int          due;
  } req_t;

  req_t        pend[$];
  logic [31:0] mq[$];
  logic [31:0] fpc;
  int          epoch;
  int          cyc;
  int          lat_max;

  int          vectors;
  int          miscompares;
  int          grants_seen;
  int          first_grant_cyc;
  int          first_valid_cyc;
  bit          want_first;
  logic [31:0] first_pc;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    pend.delete();
    mq.delete();
    fpc = RESET_PC;
    epoch++;
  endtask

  // Assert reset between clock edges, check outputs clear at once, release mid-cycle.
  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n       = 1'b0;
    jump_flag   = 1'b0;
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    inst_ready  = 1'b0;
    model_reset();
    #1;
    check("rst_req",   imem_req,   0);
    check("rst_valid", inst_valid, 0);
    check("rst_hold",  hold_flag,  1);
    check("rst_inst",  inst,       0);
    check("rst_pc",    inst_pc,    0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  task automatic step(input bit jmp, input logic [31:0] jaddr, input bit gnt,
                      input bit rdy, input bit rsp_ok);
    bit          rv;
    bit          exp_req;
    bit          exp_valid;
    req_t        r;
    logic [31:0] head;
    @(negedge clk);
    rv = rsp_ok && pend.size() > 0 && pend[0].due <= cyc;
    jump_flag   = jmp;
    jump_addr   = jaddr;
    imem_gnt    = gnt;
    imem_rvalid = rv;
    imem_rdata  = rv ? inst_of(pend[0].addr) : $urandom;
    inst_ready  = rdy;
    #1;
    exp_req   = !jmp && (pend.size() + mq.size() < DEPTH);
    exp_valid = mq.size() > 0;
    check("req",   imem_req,   exp_req);
    if (exp_req) check("addr", imem_addr, fpc);
    check("valid", inst_valid, exp_valid);
    check("hold",  hold_flag,  !exp_valid);
    if (exp_valid) begin
      head = mq[0];
      check("inst_pc", inst_pc, head);
      check("inst",    inst,    inst_of(head));
    end
    if (imem_req && imem_gnt) begin
      grants_seen++;
      if (first_grant_cyc < 0) first_grant_cyc = cyc;
    end
    if (inst_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
    if (exp_valid && rdy && !jmp) begin
      if (want_first) begin
        first_pc   = inst_pc;
        want_first = 1'b0;
      end
      void'(mq.pop_front());
    end
    if (rv) begin
      r = pend.pop_front();
      if (r.epoch == epoch && !jmp) mq.push_back(r.addr);
    end
    if (exp_req && gnt) begin
      pend.push_back('{addr: fpc, epoch: epoch, due: cyc + 1 + int'($urandom_range(0, lat_max))});
      fpc = fpc + 32'd4;
    end
    if (jmp) begin
      epoch++;
      mq.delete();
      fpc = {jaddr[31:2], 2'b00};
    end
    cyc++;
  endtask

  initial begin
    logic [31:0] ja;
    vectors = 0; miscompares = 0; cyc = 0; epoch = 0; lat_max = 0;
    want_first = 1'b0; first_pc = '0;
    rst_n = 1'b0; jump_flag = 1'b0; jump_addr = '0; imem_gnt = 1'b0;
    imem_rvalid = 1'b0; imem_rdata = '0; inst_ready = 1'b0;
    model_reset();

    // Streaming from reset: sequential addresses, head valid two cycles after grant.
    do_reset();
    first_grant_cyc = -1; first_valid_cyc = -1;
    repeat (8) step(0, '0, 1, 1, 1);
    check("first_valid_latency", 32'(first_valid_cyc - first_grant_cyc), 2);

    // Decode stalled: issue caps at DEPTH, then resumes on ready.
    do_reset();
    grants_seen = 0;
    repeat (10) step(0, '0, 1, 0, 1);
    check("cap_grants", 32'(grants_seen), DEPTH);
    check("cap_req",    imem_req,  0);
    check("cap_hold",   hold_flag, 0);
    grants_seen = 0;
    repeat (6) step(0, '0, 1, 1, 1);
    check("resume", 32'(grants_seen != 0), 1);

    // Jump with three responses in flight.
    do_reset();
    repeat (3) step(0, '0, 1, 1, 0);
    step(1, 32'h8000_0102, 1, 1, 0);
    want_first = 1'b1; first_pc = '0;
    repeat (12) step(0, '0, 1, 1, 1);
    check("jump_first_pc", first_pc, 32'h8000_0100);

    // Second jump while two stale responses are still pending.
    do_reset();
    repeat (3) step(0, '0, 1, 1, 0);
    step(1, 32'h8000_0102, 1, 1, 0);
    step(0, '0, 1, 1, 1);
    step(1, 32'h8000_0200, 1, 1, 0);
    want_first = 1'b1; first_pc = '0;
    repeat (14) step(0, '0, 1, 1, 1);
    check("jump2_first_pc", first_pc, 32'h8000_0200);

    // Grant withheld: request held stable, FIFO drains to a bubble.
    lat_max = 1;
    repeat (10) step(0, '0, 0, 1, 1);
    check("gntlow_req",  imem_req,  1);
    check("gntlow_addr", imem_addr, fpc);
    check("drain_hold",  hold_flag, 1);

    // Async reset in the middle of a burst.
    lat_max = 2;
    repeat (6) step(0, '0, 1, 1, 1);
    do_reset();
    repeat (6) step(0, '0, 1, 1, 1);

    // Random traffic, including a redirect near the top of the address space.
    lat_max = 3;
    for (int i = 0; i < 400; i++) begin
      ja = (i == 200) ? 32'hFFFF_FFF6 : $urandom;
      step(($urandom_range(0, 15) == 0) || (i == 200), ja,
           $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7,
           $urandom_range(0, 9) < 7);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
